// File: rtl/decoder_pkg.sv
// Decoder types shared by the ID stage and its consumers.
// Instruction layout: [31:26] opcode, [25:21] rd (or cond code in [25:23]),
// [20:16] rs1, [15:11] rs2, [15:0] imm16.
package decoder_pkg;

  typedef enum logic [5:0] {
    OP_ADD   = 6'd0,
    OP_ADDI  = 6'd1,
    OP_LUI   = 6'd2,
    OP_AUIPC = 6'd3,
    OP_LD    = 6'd4,
    OP_CMP   = 6'd5,
    OP_BC    = 6'd6,
    OP_JR    = 6'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_CMP = 3'd2
  } alu_t;

  typedef struct packed {
    alu_t        alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] branch_off;
    logic [2:0]  cond_code;
    logic        op1_0;
    logic        op1_pc;
    logic        op2_imm;
    logic        r_rs1;
    logic        r_rs2;
    logic        r_cr;
    logic        wrd;
    logic        wcr;
    logic        load;
    logic        branch;
    logic        branch_op1;
  } decoded_t;

endpackage

// File: rtl/id_pkg.sv
// ID-stage local types: fetch-queue entry layout, pointer width helper, x0.
package id_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Base-width (32-bit) fetch-queue entry; also the queue's default element type.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Pointers carry one extra wrap bit to tell full from empty.
  function automatic int qptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/decoder.sv
// Combinational instruction decoder producing decoded_t.
module decoder
  import decoder_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [31:0] sext16;
  logic [31:0] upper16;

  assign sext16  = {{16{instr[15]}}, instr[15:0]};
  assign upper16 = {instr[15:0], 16'h0000};

  // Field extraction and per-opcode control bits; unknown opcodes decode as NOP.
  always_comb begin
    dec            = '0;
    dec.alu        = ALU_NOP;
    dec.rd         = instr[25:21];
    dec.rs1        = instr[20:16];
    dec.rs2        = instr[15:11];
    case (opcode_t'(instr[31:26]))
      OP_ADD: begin
        dec.alu = ALU_ADD; dec.r_rs1 = 1'b1; dec.r_rs2 = 1'b1; dec.wrd = 1'b1;
      end
      OP_ADDI: begin
        dec.alu = ALU_ADD; dec.r_rs1 = 1'b1; dec.op2_imm = 1'b1; dec.imm = sext16; dec.wrd = 1'b1;
      end
      OP_LUI: begin
        dec.alu = ALU_ADD; dec.op1_0 = 1'b1; dec.op2_imm = 1'b1; dec.imm = upper16; dec.wrd = 1'b1;
      end
      OP_AUIPC: begin
        dec.alu = ALU_ADD; dec.op1_pc = 1'b1; dec.op2_imm = 1'b1; dec.imm = upper16; dec.wrd = 1'b1;
      end
      OP_LD: begin
        dec.alu = ALU_ADD; dec.r_rs1 = 1'b1; dec.op2_imm = 1'b1; dec.imm = sext16;
        dec.wrd = 1'b1; dec.load = 1'b1;
      end
      OP_CMP: begin
        dec.alu = ALU_CMP; dec.r_rs1 = 1'b1; dec.r_rs2 = 1'b1; dec.wcr = 1'b1;
      end
      OP_BC: begin
        dec.branch = 1'b1; dec.r_cr = 1'b1; dec.cond_code = instr[25:23];
        dec.branch_off = {sext16[29:0], 2'b00};
      end
      OP_JR: begin
        dec.branch = 1'b1; dec.branch_op1 = 1'b1; dec.r_rs1 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_fetch_q.sv
// Parametrised FIFO for fetch entries; clear wins over push/pop.
module id_fetch_q
  import id_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int PW = qptr_w(DEPTH);
  localparam int AW = PW - 1;

  T             mem [DEPTH];
  logic [PW-1:0] wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  // Pointer update; pointers wrap naturally through the extra bit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + 1'b1;
      if (pop  && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/stage_id_q.sv
// Decode/operand stage: fetch queue -> decode -> forward/regfile operand select
// -> valid/ready output register. Resolves branches and load-use interlocks.
// Optional build macro ID_PERF_CNT_EN adds perf_stall/perf_empty counters.
module stage_id_q
  import id_pkg::*;
  import decoder_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 4,
  parameter int NFWD   = 3,
  parameter int CRW    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [XLEN-1:0]           in_nextpc,
  input  logic [31:0]               in_instr,
  input  logic [NFWD-1:0]           fwd_wrd,
  input  logic [NFWD-1:0][4:0]      fwd_rd,
  input  logic [NFWD-1:0][XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]           fwd_pend,
  input  logic [NFWD-1:0]           fwd_wcr,
  input  logic [NFWD-1:0][CRW-1:0]  fwd_cr,
  input  logic [CRW-1:0]            cmp_reg,
  output logic [1:0][4:0]           rf_raddr,
  input  logic [1:0][XLEN-1:0]      rf_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [XLEN-1:0]           out_nextpc,
  output decoded_t                  out_dec,
  output logic [XLEN-1:0]           out_op1,
  output logic [XLEN-1:0]           out_op2,
  output logic                      out_cond,
  output logic                      branch,
  output logic [XLEN-1:0]           branch_dest,
  output logic                      stall
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]               perf_stall,
  output logic [31:0]               perf_empty
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] nextpc;
    logic [31:0]     instr;
  } entry_t;

  entry_t              q_in, head;
  logic                q_full, q_empty, head_valid;
  logic                push, issue;
  decoded_t            dec;
  logic [1:0][4:0]     rs;
  logic [1:0][XLEN-1:0] fv;
  logic [1:0]          fpend;
  logic [CRW-1:0]      cr_val;
  logic [XLEN-1:0]     op1, op2, imm, boff;
  logic                cond;

  assign q_in       = '{pc: in_pc, nextpc: in_nextpc, instr: in_instr};
  assign head_valid = !q_empty;
  assign in_ready   = !q_full;
  // A taken branch kills anything fetched alongside it.
  assign push       = in_valid && !q_full && !flush && !branch;

  id_fetch_q #(.T(entry_t), .DEPTH(QDEPTH)) u_q (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (issue),
    .clear (flush || branch),
    .din   (q_in),
    .full  (q_full),
    .empty (q_empty),
    .head  (head)
  );

  decoder u_dec (.instr(head.instr), .dec(dec));

  assign rs       = {dec.rs2, dec.rs1};
  assign rf_raddr = rs;
  assign imm      = XLEN'($signed(dec.imm));
  assign boff     = XLEN'($signed(dec.branch_off));

  // Forward mux per source: scan oldest->youngest so index 0 wins; x0 never forwards.
  always_comb begin
    fv    = rf_rdata;
    fpend = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = NFWD - 1; i >= 0; i--) begin
        if (fwd_wrd[i] && fwd_rd[i] == rs[s] && rs[s] != REG_ZERO) begin
          fv[s]    = fwd_data[i];
          fpend[s] = fwd_pend[i];
        end
      end
    end
  end

  // Compare-result select: youngest in-flight cr writer, else the architectural cr.
  always_comb begin
    cr_val = cmp_reg;
    for (int i = NFWD - 1; i >= 0; i--)
      if (fwd_wcr[i]) cr_val = fwd_cr[i];
  end

  assign op1   = dec.op1_0 ? '0 : (dec.op1_pc ? head.pc : fv[0]);
  assign op2   = dec.op2_imm ? imm : fv[1];
  assign cond  = !dec.r_cr || ((cr_val == CRW'(dec.cond_code[2:1])) ^ dec.cond_code[0]);
  assign stall = head_valid && ((fpend[0] && dec.r_rs1) || (fpend[1] && dec.r_rs2));
  assign issue = head_valid && !stall && (!out_valid || out_ready) && !flush;

  assign branch      = issue && dec.branch && cond;
  assign branch_dest = dec.branch_op1 ? {op1[XLEN-1:2], 2'b00} : head.pc + boff;

  // Output register: load on issue, drop valid once EX takes it, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_nextpc <= '0;
      out_dec    <= '0;
      out_op1    <= '0;
      out_op2    <= '0;
      out_cond   <= 1'b0;
    end else if (issue) begin
      out_valid  <= 1'b1;
      out_pc     <= head.pc;
      out_nextpc <= head.nextpc;
      out_dec    <= dec;
      out_op1    <= op1;
      out_op2    <= op2;
      out_cond   <= cond;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef ID_PERF_CNT_EN
  // Interlock and starvation cycle counters; survive flush, wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= '0;
      perf_empty <= '0;
    end else begin
      if (stall)   perf_stall <= perf_stall + 32'd1;
      if (q_empty) perf_empty <= perf_empty + 32'd1;
    end
  end
`else
  // Counters not built.
`endif

endmodule
